// File: rtl/addr_gen_pkg.sv
// -----------------------------------------------------------------------------
// addr_gen_pkg
// Shared types and default constants for the multi-channel 2-D address
// generator (addr_gen_multi and its addr_gen_channel sub-module).
//   ch_state_t  : per-channel life cycle (unloaded / walking / finished)
//   DEF_*       : default parameter values
//   sel_width() : selector width for a given channel count (minimum 1 bit)
// -----------------------------------------------------------------------------
package addr_gen_pkg;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,   // never loaded since reset
        CH_ACTIVE = 2'd1,   // walking its region, accepts steps
        CH_DONE   = 2'd2    // region exhausted or zero-sized
    } ch_state_t;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_CNT_W  = 5;
    localparam int DEF_NUM_CH = 3;

    // A single channel still needs a 1-bit selector so the port exists.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addr_gen_if.sv
// -----------------------------------------------------------------------------
// addr_gen_if
// Step request / address response bundle of the address generator.
//   step, sel               : request one address from channel sel
//   addr, addr_ch, addr_valid : registered response, valid for one cycle
// Modports: master (requester) drives step/sel, slave (generator) drives
// the response.
// -----------------------------------------------------------------------------
interface addr_gen_if
    import addr_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEL_W  = sel_width(DEF_NUM_CH)
);
    logic              step;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  addr_ch;
    logic              addr_valid;

    modport master (
        output step, sel,
        input  addr, addr_ch, addr_valid
    );

    modport slave (
        input  step, sel,
        output addr, addr_ch, addr_valid
    );
endinterface

// File: rtl/addr_gen_channel.sv
// -----------------------------------------------------------------------------
// addr_gen_channel
// One channel of the 2-D address generator: latched configuration, row base,
// column/row counters, life-cycle state and the address adder.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   load             : latch cfg_* and rewind (highest priority after reset)
//   cfg_base/cols/rows/stride : configuration for this channel
//   restart          : rewind to the latched base (ignored while unloaded)
//   step_req         : step addressed to this channel, already free of load
//   fire             : step accepted this cycle (combinational)
//   beat_addr        : row_base + col_cnt for the current beat (combinational)
//   beat_carry       : adder carry-out (only with ADDR_GEN_BOUNDS_CHECK_EN)
//   done             : channel is in CH_DONE (registered)
// Macro: ADDR_GEN_BOUNDS_CHECK_EN widens the adder by one bit to expose carry.
// -----------------------------------------------------------------------------
module addr_gen_channel
    import addr_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_cols,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic              restart,
    input  logic              step_req,
    output logic              fire,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              beat_carry,
    output logic              done
);

    ch_state_t         state_q,    state_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [CNT_W-1:0]  cols_q,     cols_d;
    logic [CNT_W-1:0]  rows_q,     rows_d;
    logic [ADDR_W-1:0] stride_q,   stride_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [CNT_W-1:0]  col_cnt_q,  col_cnt_d;
    logic [CNT_W-1:0]  row_cnt_q,  row_cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        base_d     = base_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        fire       = 1'b0;

        if (load) begin
            base_d     = cfg_base;
            cols_d     = cfg_cols;
            rows_d     = cfg_rows;
            stride_d   = cfg_stride;
            row_base_d = cfg_base;
            col_cnt_d  = '0;
            row_cnt_d  = '0;
            state_d    = (cfg_cols == '0 || cfg_rows == '0) ? CH_DONE : CH_ACTIVE;
        end else if (restart && state_q != CH_IDLE) begin
            row_base_d = base_q;
            col_cnt_d  = '0;
            row_cnt_d  = '0;
            state_d    = (cols_q == '0 || rows_q == '0) ? CH_DONE : CH_ACTIVE;
        end else if (step_req && state_q == CH_ACTIVE) begin
            fire = 1'b1;
            // CH_ACTIVE guarantees cols/rows >= 1, so the -1 cannot underflow.
            if (col_cnt_q == cols_q - CNT_W'(1)) begin
                col_cnt_d  = '0;
                row_base_d = row_base_q + stride_q;
                row_cnt_d  = row_cnt_q + CNT_W'(1);
                if (row_cnt_q == rows_q - CNT_W'(1)) begin
                    state_d = CH_DONE;
                end
            end else begin
                col_cnt_d = col_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CH_IDLE;
            base_q     <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    localparam int SUM_W = ADDR_W + 1;
    logic [SUM_W-1:0] sum_ext;
    assign sum_ext    = {1'b0, row_base_q} + SUM_W'(col_cnt_q);
    assign beat_addr  = sum_ext[ADDR_W-1:0];
    assign beat_carry = sum_ext[ADDR_W];
`else
    // Plain modulo-2^ADDR_W wrap; no overflow detection.
    assign beat_addr  = row_base_q + ADDR_W'(col_cnt_q);
    assign beat_carry = 1'b0;
`endif

    assign done = (state_q == CH_DONE);

endmodule

// File: rtl/addr_gen_multi.sv
// -----------------------------------------------------------------------------
// addr_gen_multi
// Multi-channel 2-D address generator. Each channel walks cols x rows
// addresses with a per-row stride; one channel is stepped per cycle via sel
// and the chosen address is registered with one cycle of latency.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : latch cfg_* into every channel, clears err
//   cfg_base     : NUM_CH*ADDR_W first address per channel (ch0 in LSBs)
//   cfg_cols     : NUM_CH*CNT_W  addresses per row
//   cfg_rows     : NUM_CH*CNT_W  row count
//   cfg_stride   : NUM_CH*ADDR_W row-base increment
//   ch_restart   : NUM_CH per-channel rewind to latched base
//   bus (slave)  : step/sel request, addr/addr_ch/addr_valid response
//   done         : NUM_CH per-channel completion level
//   all_done     : AND of done
//   err          : sticky address overflow
// Macro: ADDR_GEN_BOUNDS_CHECK_EN - when defined, beats whose address carries
// out of ADDR_W bits are suppressed and set err; otherwise addresses wrap and
// err is tied low.
// -----------------------------------------------------------------------------
module addr_gen_multi
    import addr_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_base,
    input  logic [NUM_CH*CNT_W-1:0]  cfg_cols,
    input  logic [NUM_CH*CNT_W-1:0]  cfg_rows,
    input  logic [NUM_CH*ADDR_W-1:0] cfg_stride,
    input  logic [NUM_CH-1:0]        ch_restart,
    addr_gen_if.slave                bus,
    output logic [NUM_CH-1:0]        done,
    output logic                     all_done,
    output logic                     err
);

    logic [NUM_CH-1:0] step_req;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] beat_carry;
    logic [ADDR_W-1:0] beat_addr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range sel matches no channel, so it is dropped here.
        // load beats any step; restart blocking is handled in the channel.
        assign step_req[i] = bus.step && !load && (bus.sel == SEL_W'(i));

        addr_gen_channel #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .cfg_base   (cfg_base[i*ADDR_W +: ADDR_W]),
            .cfg_cols   (cfg_cols[i*CNT_W +: CNT_W]),
            .cfg_rows   (cfg_rows[i*CNT_W +: CNT_W]),
            .cfg_stride (cfg_stride[i*ADDR_W +: ADDR_W]),
            .restart    (ch_restart[i]),
            .step_req   (step_req[i]),
            .fire       (fire[i]),
            .beat_addr  (beat_addr[i]),
            .beat_carry (beat_carry[i]),
            .done       (done[i])
        );
    end

    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [SEL_W-1:0]  addr_ch_q,    addr_ch_d;
    logic              addr_valid_q, addr_valid_d;
    logic              carry_hit;

    // At most one channel fires per cycle because step_req is decoded from sel.
    always_comb begin
        addr_d       = addr_q;
        addr_ch_d    = addr_ch_q;
        addr_valid_d = 1'b0;
        carry_hit    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (fire[i]) begin
                addr_d       = beat_addr[i];
                addr_ch_d    = SEL_W'(i);
                addr_valid_d = !beat_carry[i];
                carry_hit    = beat_carry[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            addr_ch_q    <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            addr_ch_q    <= addr_ch_d;
            addr_valid_q <= addr_valid_d;
        end
    end

`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (load) begin
            err_d = 1'b0;
        end else if (carry_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Without bounds checking carry_hit is constant low; err is tied off.
    assign err = 1'b0;
`endif

    assign bus.addr       = addr_q;
    assign bus.addr_ch    = addr_ch_q;
    assign bus.addr_valid = addr_valid_q;
    assign all_done       = &done;

endmodule

// File: tb/tb_addr_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_addr_gen_multi
// Directed self-checking bench for addr_gen_multi at default parameters
// (ADDR_W 7, CNT_W 5, NUM_CH 3). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, i.e. the response to the
// preceding edge. Overflow expectations follow ADDR_GEN_BOUNDS_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_addr_gen_multi;

    localparam int ADDR_W = 7;
    localparam int CNT_W  = 5;
    localparam int NUM_CH = 3;
    localparam int SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     load;
    logic [NUM_CH*ADDR_W-1:0] cfg_base;
    logic [NUM_CH*CNT_W-1:0]  cfg_cols;
    logic [NUM_CH*CNT_W-1:0]  cfg_rows;
    logic [NUM_CH*ADDR_W-1:0] cfg_stride;
    logic [NUM_CH-1:0]        ch_restart;
    logic [NUM_CH-1:0]        done;
    logic                     all_done;
    logic                     err;

    addr_gen_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

    addr_gen_multi #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .cfg_base   (cfg_base),
        .cfg_cols   (cfg_cols),
        .cfg_rows   (cfg_rows),
        .cfg_stride (cfg_stride),
        .ch_restart (ch_restart),
        .bus        (bus),
        .done       (done),
        .all_done   (all_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int base, input int cols,
                          input int rows, input int stride);
        cfg_base[ch*ADDR_W +: ADDR_W]   = ADDR_W'(base);
        cfg_cols[ch*CNT_W +: CNT_W]     = CNT_W'(cols);
        cfg_rows[ch*CNT_W +: CNT_W]     = CNT_W'(rows);
        cfg_stride[ch*ADDR_W +: ADDR_W] = ADDR_W'(stride);
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // One step request; checks valid, and address/channel when a beat is expected.
    task automatic do_step(input string tag, input int s, input bit exp_valid, input int exp_addr);
        bus.sel  = SEL_W'(s);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check({tag, "_valid"}, 32'(bus.addr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({tag, "_addr"}, 32'(bus.addr), 32'(exp_addr));
            check({tag, "_ch"}, 32'(bus.addr_ch), 32'(s));
        end
    endtask

    // Ch0 base 10 / cols 4 / rows 3 / stride 16, ch1 and ch2 zero-sized.
    task automatic cfg_single();
        set_ch(0, 10, 4, 3, 16);
        set_ch(1, 0, 0, 1, 0);
        set_ch(2, 0, 0, 1, 0);
    endtask

    int exp_single [12] = '{10, 11, 12, 13, 26, 27, 28, 29, 42, 43, 44, 45};
    int exp_inter  [7]  = '{0, 100, 1, 101, 8, 102, 9};
    int exp_ovf    [10] = '{120, 121, 122, 123, 124, 125, 126, 127, 0, 1};

    initial begin
        rst_n      = 1'b1;
        load       = 1'b0;
        cfg_base   = '0;
        cfg_cols   = '0;
        cfg_rows   = '0;
        cfg_stride = '0;
        ch_restart = '0;
        bus.step   = 1'b0;
        bus.sel    = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_addr", 32'(bus.addr), 0);
        check("rst_addr_ch", 32'(bus.addr_ch), 0);
        check("rst_valid", 32'(bus.addr_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_all_done", 32'(all_done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();

        // Stepping an unloaded channel yields nothing.
        do_step("idle_step", 0, 1'b0, 0);

        // ---------------- single channel walk ----------------
        cfg_single();
        do_load();
        check("single_done_after_load", 32'(done), 32'(3'b110));
        for (int k = 0; k < 12; k++) begin
            do_step($sformatf("single_%0d", k), 0, 1'b1, exp_single[k]);
            if (k == 4) begin
                // Out-of-range selector in mid-walk: dropped, walk unaffected.
                do_step("sel3", 3, 1'b0, 0);
            end
            if (k == 10) check("single_done0_early", 32'(done[0]), 0);
        end
        check("single_done0_last", 32'(done[0]), 1);
        check("single_all_done", 32'(all_done), 1);
        do_step("single_13th", 0, 1'b0, 0);

        // ---------------- interleaved channels ----------------
        set_ch(0, 0, 2, 2, 8);
        set_ch(1, 100, 3, 1, 0);
        set_ch(2, 0, 0, 1, 0);
        do_load();
        check("inter_done_after_load", 32'(done), 32'(3'b100));
        for (int k = 0; k < 7; k++) begin
            do_step($sformatf("inter_%0d", k), k % 2, 1'b1, exp_inter[k]);
            if (k == 3) check("inter_done_mid", 32'(done), 32'(3'b100));
            if (k == 5) begin
                check("inter_done1", 32'(done), 32'(3'b110));
                check("inter_all_done_early", 32'(all_done), 0);
            end
        end
        check("inter_all_done", 32'(all_done), 1);
        // A finished channel accepts no more steps.
        do_step("inter_done_step", 1, 1'b0, 0);

        // ---------------- collisions ----------------
        cfg_single();
        load     = 1'b1;
        bus.sel  = '0;
        bus.step = 1'b1;
        tick();
        load     = 1'b0;
        bus.step = 1'b0;
        check("load_step_valid", 32'(bus.addr_valid), 0);
        do_step("coll_a", 0, 1'b1, 10);
        do_step("coll_b", 0, 1'b1, 11);
        ch_restart = 3'b001;
        do_step("restart_step", 0, 1'b0, 0);
        ch_restart = '0;
        do_step("after_restart", 0, 1'b1, 10);
        ch_restart = 3'b010;
        do_step("other_restart", 0, 1'b1, 11);
        ch_restart = '0;

        // ---------------- overflow ----------------
        set_ch(0, 120, 10, 1, 0);
        do_load();
        for (int k = 0; k < 10; k++) begin
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
            do_step($sformatf("ovf_%0d", k), 0, (k < 8), exp_ovf[k]);
            check($sformatf("ovf_err_%0d", k), 32'(err), (k >= 8) ? 1 : 0);
`else
            do_step($sformatf("ovf_%0d", k), 0, 1'b1, exp_ovf[k]);
            check($sformatf("ovf_err_%0d", k), 32'(err), 0);
`endif
        end
        check("ovf_done0", 32'(done[0]), 1);
        do_load();
        check("ovf_err_cleared", 32'(err), 0);

        // ---------------- asynchronous reset mid-row ----------------
        cfg_single();
        do_load();
        do_step("arst_a", 0, 1'b1, 10);
        do_step("arst_b", 0, 1'b1, 11);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr", 32'(bus.addr), 0);
        check("arst_valid", 32'(bus.addr_valid), 0);
        check("arst_done", 32'(done), 0);
        check("arst_all_done", 32'(all_done), 0);
        check("arst_err", 32'(err), 0);
        #2 rst_n = 1'b1;
        do_step("arst_step_ignored", 0, 1'b0, 0);
        do_load();
        do_step("arst_reload", 0, 1'b1, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addr_gen_multi.md
# addr_gen_multi

Parametrised multi-channel 2-D address generator for the CA datapath memories; successor to the fixed three-stream (x/y/z) generator. Each channel walks a rectangular region (`cols` addresses per row, `rows` rows, row base advanced by `stride`) and emits one registered address per accepted step. Channels are configured together, stepped one at a time via `sel`, and report per-channel and global completion.

## Interface
- `ADDR_W`, default 7: address width.
- `CNT_W`, default 5: column/row counter width.
- `NUM_CH`, default 3: number of channels.
- `SEL_W`, default `$clog2(NUM_CH)`, derived: selector width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  latch all `cfg_*` for every channel.
- `cfg_base`  in  NUM_CH*ADDR_W  first address per channel (ch0 in LSBs).
- `cfg_cols`  in  NUM_CH*CNT_W  addresses per row.
- `cfg_rows`  in  NUM_CH*CNT_W  row count.
- `cfg_stride`  in  NUM_CH*ADDR_W  row-base increment.
- `ch_restart`  in  NUM_CH  per-channel rewind to latched base.
- `sel`  in  SEL_W  channel to step.
- `step`  in  1  request one address from channel `sel`.
- `addr`  out  ADDR_W  generated address.
- `addr_ch`  out  SEL_W  channel that produced `addr`.
- `addr_valid`  out  1  `addr` valid this cycle.
- `done`  out  NUM_CH  channel finished (level).
- `all_done`  out  1  AND of `done`.
- `err`  out  1  sticky address overflow (see Configuration).

## Operation
- Per-channel state: `CH_IDLE` (unloaded), `CH_ACTIVE`, `CH_DONE`; registers `row_base`, `col_cnt`, `row_cnt`.
- `load`: every channel gets `row_base=cfg_base`, counters 0. State becomes `CH_ACTIVE`; `CH_DONE` if its `cols==0` or `rows==0`. Clears `err`.
- `ch_restart[i]`: channel i rewinds to latched base, counters 0, state as for `load`. Ignored in `CH_IDLE`.
- Step accepted only if `sel<NUM_CH` and channel `sel` is `CH_ACTIVE`; otherwise dropped, no valid.
- Accepted step: `addr = row_base + col_cnt` (mod 2^ADDR_W; `col_cnt` zero-extended); `col_cnt++`. If `col_cnt==cols-1`: `col_cnt=0`, `row_base+=stride`, `row_cnt++`. If also `row_cnt==rows-1`: state becomes `CH_DONE`.
- Priority: `rst_n` > `load` > `ch_restart` > `step`. `load` and `step` together: step dropped. Restart and step on the same channel: step dropped. Restart of another channel does not block the step.
- `CH_DONE` persists until `load`, restart or reset.

## Timing
- Reset values: `addr=0`, `addr_ch=0`, `addr_valid=0`, `done=0` (all `CH_IDLE`), `all_done=0`, `err=0`.
- Latency 1: step accepted at edge N gives `addr`/`addr_ch`/`addr_valid` registered at N, valid for one cycle. Back-to-back steps give one address per cycle.
- `done[i]` rises in the same cycle as the channel's last `addr_valid`.
- A zero-dimension channel shows `done` the cycle after `load`.
- `all_done` is combinational from registered `done`.
- Async reset mid-run forces reset values immediately. Steps are then ignored until `load`.

## Configuration
- `ADDR_GEN_BOUNDS_CHECK_EN` defined: the sum is computed at ADDR_W+1 bits. On carry, that beat is suppressed (`addr_valid=0`), counters still advance, and `err` sets sticky until `load`/reset.
- Not defined: addresses wrap modulo 2^ADDR_W, and `err` is tied 0.

## Structure
- Package `addr_gen_pkg`:
  - `ch_state_t` enum (`CH_IDLE`, `CH_ACTIVE`, `CH_DONE`).
  - Default parameter constants.
- Sub-module `addr_gen_channel`: one channel's counters, state and adder. Instantiated NUM_CH times in a generate loop.
- Top level: output mux/registers and `err`/`all_done`.

## Test plan
- Single channel: ch0 base 10, cols 4, rows 3, stride 16; 13 steps.
  - Valid addresses: 10,11,12,13,26,27,28,29,42,43,44,45.
  - `done[0]` rises with 45; the 13th step gives no valid.
- Interleave:
  - Config: ch0 base 0/cols 2/rows 2/stride 8; ch1 base 100/cols 3/rows 1; ch2 cols 0.
  - After `load`: `done[2]=1` the next cycle.
  - Alternate sel 0,1: addresses 0,100,1,101,8,102,9.
  - `done[1]` with 102; `all_done` with 9.
- Collisions:
  - `load`+`step` same cycle: no valid.
  - Ch0 mid-row at `col_cnt=2`: `ch_restart[0]`+`step` gives no valid; next step gives `base`.
- Overflow: ADDR_W 7, base 120, cols 10, rows 1.
  - With macro: 120..127 valid, 9th beat suppressed, `err=1`, 10th beat suppressed.
  - Without macro: 120..127,0,1, `err=0`.
- `sel=3` with NUM_CH 3, or stepping a `CH_IDLE` channel: no valid, no state change.
- Assert `rst_n=0` asynchronously mid-row: all outputs 0 before the next edge; steps ignored until `load`.
